// File: rtl/morra_pkg.sv
// Shared types and helpers for the morra match driver: move/result encodings,
// FSM states and the anti-repeat move rotation.
package morra_pkg;

    typedef enum logic [1:0] {
        MV_NONE    = 2'b00,
        MV_SASSO   = 2'b01,
        MV_CARTA   = 2'b10,
        MV_FORBICE = 2'b11
    } move_t;

    typedef enum logic [1:0] {
        RES_NONE = 2'b00,
        RES_P1   = 2'b01,
        RES_P2   = 2'b10,
        RES_DRAW = 2'b11
    } result_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONFIG,
        ST_ISSUE,
        ST_WAIT,
        ST_CHECK,
        ST_FINISH
    } state_t;

    localparam logic [15:0] SEED_DEFAULT = 16'hACE1;

    // A no-move stays a no-move; real moves cycle sasso -> carta -> forbice.
    function automatic move_t rotate_move(input move_t m);
        case (m)
            MV_SASSO:   return MV_CARTA;
            MV_CARTA:   return MV_FORBICE;
            MV_FORBICE: return MV_SASSO;
            default:    return MV_NONE;
        endcase
    endfunction

endpackage

// File: rtl/morra_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), shifting left with feedback into bit 0.
module morra_lfsr16 #(
    parameter logic [15:0] SEED_VAL = morra_pkg::SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] seed_val,
    input  logic        step,
    output logic [15:0] state
);

    logic [15:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = seed_val;
        end else if (step) begin
            state_d = {state_q[14:0], state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= SEED_VAL;
        else       state_q <= state_d;
    end

    assign state = state_q;

endmodule

// File: rtl/morra_match_driver.sv
// Player-side match driver: configures the referee, issues move pairs (LFSR or host),
// enforces the no-repeat-winning-move rule and collects round/match results.
//
// state   | meaning
// IDLE    | waiting for start
// CONFIG  | referee held in reset, cfg_extra presented on {g1,g2}
// ISSUE   | produce next move pair (host handshake in manual mode)
// WAIT    | hold moves while the referee resolves the round
// CHECK   | sample manche/partita, update blocks and round count
// FINISH  | one-cycle done pulse, back to IDLE
module morra_match_driver #(
    parameter logic [15:0] SEED_DEFAULT = morra_pkg::SEED_DEFAULT,
    parameter int          RESP_LAT     = 1,
    parameter int          MAX_ROUNDS   = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  cfg_extra,
    input  logic [15:0] seed,
    input  logic        manual,
    input  logic        man_valid,
    input  logic [1:0]  man_g1,
    input  logic [1:0]  man_g2,
    output logic        man_ready,
    input  logic [1:0]  manche_in,
    input  logic [1:0]  partita_in,
    output logic        ref_reset,
    output logic [1:0]  g1,
    output logic [1:0]  g2,
    output logic        busy,
    output logic        done,
    output logic [1:0]  winner,
    output logic [4:0]  rounds,
    output logic        timeout
);
    import morra_pkg::*;

    localparam int         WAIT_LOAD_I = (RESP_LAT > 2) ? RESP_LAT - 2 : 0;
    localparam logic [1:0] WAIT_LOAD   = 2'(WAIT_LOAD_I);
    localparam logic [4:0] ROUNDS_MAX  = 5'(MAX_ROUNDS);

    state_t      state_q, state_d;
    logic        manual_q, manual_d;
    logic [1:0]  g1_q, g1_d, g2_q, g2_d;
    logic        ref_reset_q, ref_reset_d;
    logic        busy_q, busy_d, done_q, done_d, timeout_q, timeout_d;
    logic [1:0]  winner_q, winner_d;
    logic [4:0]  rounds_q, rounds_d;
    logic        p1_blk_q, p1_blk_d, p2_blk_q, p2_blk_d;
    logic [1:0]  p1_last_q, p1_last_d, p2_last_q, p2_last_d;
    logic [1:0]  wait_cnt_q, wait_cnt_d;

    logic        lfsr_load, lfsr_step;
    logic [15:0] lfsr_seed, lfsr_state;
    logic [1:0]  raw1, raw2, src1, src2, mv1, mv2;

    function automatic logic [1:0] apply_block(input logic [1:0] mv, input logic blk,
                                               input logic [1:0] last);
        logic [1:0] r;
        r = mv;
        if (blk && (mv == last)) r = rotate_move(move_t'(mv));
        return r;
    endfunction

    morra_lfsr16 #(.SEED_VAL(SEED_DEFAULT)) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (lfsr_load),
        .seed_val (lfsr_seed),
        .step     (lfsr_step),
        .state    (lfsr_state)
    );

    assign raw1 = (lfsr_state[1:0] == 2'b00) ? 2'b01 : lfsr_state[1:0];
    assign raw2 = (lfsr_state[3:2] == 2'b00) ? 2'b01 : lfsr_state[3:2];
    assign src1 = manual_q ? man_g1 : raw1;
    assign src2 = manual_q ? man_g2 : raw2;
    assign mv1  = apply_block(src1, p1_blk_q, p1_last_q);
    assign mv2  = apply_block(src2, p2_blk_q, p2_last_q);

    always_comb begin
        state_d     = state_q;
        manual_d    = manual_q;
        g1_d        = g1_q;
        g2_d        = g2_q;
        ref_reset_d = ref_reset_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        winner_d    = winner_q;
        rounds_d    = rounds_q;
        timeout_d   = timeout_q;
        p1_blk_d    = p1_blk_q;
        p2_blk_d    = p2_blk_q;
        p1_last_d   = p1_last_q;
        p2_last_d   = p2_last_q;
        wait_cnt_d  = wait_cnt_q;
        lfsr_load   = 1'b0;
        lfsr_step   = 1'b0;
        lfsr_seed   = (seed == 16'h0000) ? SEED_DEFAULT : seed;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    manual_d    = manual;
                    lfsr_load   = 1'b1;
                    rounds_d    = 5'd0;
                    winner_d    = RES_NONE;
                    timeout_d   = 1'b0;
                    p1_blk_d    = 1'b0;
                    p2_blk_d    = 1'b0;
                    p1_last_d   = MV_NONE;
                    p2_last_d   = MV_NONE;
                    ref_reset_d = 1'b1;
                    g1_d        = cfg_extra[3:2];
                    g2_d        = cfg_extra[1:0];
                    busy_d      = 1'b1;
                    state_d     = ST_CONFIG;
                end
            end
            ST_CONFIG: begin
                ref_reset_d = 1'b0;
                g1_d        = MV_NONE;
                g2_d        = MV_NONE;
                state_d     = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (!manual_q || man_valid) begin
                    g1_d       = mv1;
                    g2_d       = mv2;
                    wait_cnt_d = WAIT_LOAD;
                    state_d    = (RESP_LAT > 1) ? ST_WAIT : ST_CHECK;
                    // An all-zero LFSR would lock up; reseed rather than step.
                    if (!manual_q) begin
                        if (lfsr_state == 16'h0000) begin
                            lfsr_load = 1'b1;
                            lfsr_seed = SEED_DEFAULT;
                        end else begin
                            lfsr_step = 1'b1;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 2'd0) state_d = ST_CHECK;
                else                    wait_cnt_d = wait_cnt_q - 2'd1;
            end
            ST_CHECK: begin
                if ((manche_in != RES_NONE) && (rounds_q != 5'd31)) rounds_d = rounds_q + 5'd1;
                case (manche_in)
                    RES_P1: begin
                        p1_blk_d  = 1'b1;
                        p1_last_d = g1_q;
                        p2_blk_d  = 1'b0;
                    end
                    RES_P2: begin
                        p2_blk_d  = 1'b1;
                        p2_last_d = g2_q;
                        p1_blk_d  = 1'b0;
                    end
                    RES_DRAW: begin
                        p1_blk_d = 1'b0;
                        p2_blk_d = 1'b0;
                    end
                    default: ;
                endcase
                g1_d = MV_NONE;
                g2_d = MV_NONE;
                if (partita_in != RES_NONE) begin
                    winner_d = partita_in;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = ST_FINISH;
                end else if (rounds_d == ROUNDS_MAX) begin
                    timeout_d = 1'b1;
                    winner_d  = RES_NONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = ST_FINISH;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            manual_q    <= 1'b0;
            g1_q        <= MV_NONE;
            g2_q        <= MV_NONE;
            ref_reset_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            winner_q    <= RES_NONE;
            rounds_q    <= 5'd0;
            timeout_q   <= 1'b0;
            p1_blk_q    <= 1'b0;
            p2_blk_q    <= 1'b0;
            p1_last_q   <= MV_NONE;
            p2_last_q   <= MV_NONE;
            wait_cnt_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            manual_q    <= manual_d;
            g1_q        <= g1_d;
            g2_q        <= g2_d;
            ref_reset_q <= ref_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            winner_q    <= winner_d;
            rounds_q    <= rounds_d;
            timeout_q   <= timeout_d;
            p1_blk_q    <= p1_blk_d;
            p2_blk_q    <= p2_blk_d;
            p1_last_q   <= p1_last_d;
            p2_last_q   <= p2_last_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign man_ready = (state_q == ST_ISSUE) && manual_q;
    assign ref_reset = ref_reset_q;
    assign g1        = g1_q;
    assign g2        = g2_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign winner    = winner_q;
    assign rounds    = rounds_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_morra_match_driver.sv
// Directed bench for morra_match_driver: one instance with RESP_LAT=1 and one with RESP_LAT=3.
module tb_morra_match_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, start3, manual, man_valid;
    logic [3:0]  cfg_extra;
    logic [15:0] seed;
    logic [1:0]  man_g1, man_g2, manche_in, partita_in, manche3, partita3;

    logic        man_ready, ref_reset, busy, done, timeout;
    logic [1:0]  g1, g2, winner;
    logic [4:0]  rounds;
    logic        man_ready3, ref_reset3, busy3, done3, timeout3;
    logic [1:0]  g1_3, g2_3, winner3;
    logic [4:0]  rounds3;

    int checks = 0;
    int errors = 0;
    int n;

    morra_match_driver #(.RESP_LAT(1)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_extra(cfg_extra), .seed(seed),
        .manual(manual), .man_valid(man_valid), .man_g1(man_g1), .man_g2(man_g2),
        .man_ready(man_ready), .manche_in(manche_in), .partita_in(partita_in),
        .ref_reset(ref_reset), .g1(g1), .g2(g2), .busy(busy), .done(done),
        .winner(winner), .rounds(rounds), .timeout(timeout)
    );

    morra_match_driver #(.RESP_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .cfg_extra(cfg_extra), .seed(seed),
        .manual(manual), .man_valid(man_valid), .man_g1(man_g1), .man_g2(man_g2),
        .man_ready(man_ready3), .manche_in(manche3), .partita_in(partita3),
        .ref_reset(ref_reset3), .g1(g1_3), .g2(g2_3), .busy(busy3), .done(done3),
        .winner(winner3), .rounds(rounds3), .timeout(timeout3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1; start = 0; start3 = 0; manual = 0; man_valid = 0;
        cfg_extra = 4'h0; seed = 16'h0001; man_g1 = 0; man_g2 = 0;
        manche_in = 0; partita_in = 0; manche3 = 0; partita3 = 0;
        repeat (3) step();
        reset = 0;
        step();
        chk("rst_g1", g1, 0);           chk("rst_g2", g2, 0);
        chk("rst_ref_reset", ref_reset, 0);
        chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
        chk("rst_winner", winner, 0);   chk("rst_rounds", rounds, 0);
        chk("rst_timeout", timeout, 0); chk("rst_man_ready", man_ready, 0);
        chk("rst_lfsr", dut.lfsr_state, 16'hACE1);

        // LFSR mode, seed 1: first pair is (01, 00->01), LFSR steps to 0002
        seed = 16'h0001; cfg_extra = 4'h0; manual = 0; start = 1;
        step(); start = 0;
        chk("cfg_ref_reset", ref_reset, 1); chk("cfg_g1", g1, 0); chk("cfg_g2", g2, 0);
        chk("cfg_busy", busy, 1);
        step();
        chk("issue_ref_reset", ref_reset, 0); chk("issue_g1_idle", g1, 0);
        step();
        chk("lfsr_g1", g1, 1); chk("lfsr_g2", g2, 1);
        chk("lfsr_step", dut.lfsr_state, 16'h0002);
        manche_in = 2'b11; partita_in = 2'b11;
        step(); manche_in = 0; partita_in = 0;
        chk("t1_done", done, 1); chk("t1_winner", winner, 3);
        chk("t1_rounds", rounds, 1); chk("t1_busy", busy, 0); chk("t1_g1", g1, 0);
        step();
        chk("t1_done_low", done, 0);

        // Manual mode with blocking
        manual = 1; cfg_extra = 4'b1001; start = 1;
        step(); start = 0;
        chk("m_cfg_g1", g1, 2); chk("m_cfg_g2", g2, 1); chk("m_cfg_ready", man_ready, 0);
        step();
        chk("m_ready_issue", man_ready, 1); chk("m_issue_g1", g1, 0);
        start = 1;
        step(); start = 0;
        chk("m_start_ignored_ready", man_ready, 1); chk("m_start_ignored_ref", ref_reset, 0);
        chk("m_start_ignored_busy", busy, 1);
        man_valid = 1; man_g1 = 2'b01; man_g2 = 2'b11;
        step(); man_valid = 0;
        chk("m_r1_g1", g1, 1); chk("m_r1_g2", g2, 3); chk("m_ready_check", man_ready, 0);
        manche_in = 2'b01;
        step(); manche_in = 0;
        chk("m_r1_rounds", rounds, 1); chk("m_r1_g1_clear", g1, 0);
        man_valid = 1; man_g1 = 2'b01; man_g2 = 2'b10;
        step(); man_valid = 0;
        chk("m_r2_g1_rot", g1, 2); chk("m_r2_g2", g2, 2);
        manche_in = 2'b10;
        step(); manche_in = 0;
        chk("m_r2_rounds", rounds, 2);
        man_valid = 1; man_g1 = 2'b10; man_g2 = 2'b10;
        step(); man_valid = 0;
        chk("m_r3_g1_unblocked", g1, 2); chk("m_r3_g2_rot", g2, 3);
        manche_in = 2'b11;
        step(); manche_in = 0;
        chk("m_r3_rounds", rounds, 3);
        man_valid = 1; man_g1 = 2'b10; man_g2 = 2'b10;
        step(); man_valid = 0;
        chk("m_r4_g1", g1, 2); chk("m_r4_g2", g2, 2);
        manche_in = 2'b01; partita_in = 2'b01;
        step(); manche_in = 0; partita_in = 0;
        chk("m_done", done, 1); chk("m_winner", winner, 1); chk("m_rounds", rounds, 4);
        chk("m_busy", busy, 0); chk("m_timeout", timeout, 0);
        step();
        chk("m_done_low", done, 0); chk("m_winner_hold", winner, 1); chk("m_rounds_hold", rounds, 4);

        // Endless draws -> timeout after 31 decided rounds
        manual = 0; seed = 16'h0001; cfg_extra = 4'h0; start = 1;
        step(); start = 0;
        manche_in = 2'b11; partita_in = 2'b00;
        n = 1;
        while (done !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        manche_in = 0;
        chk("to_cycles", n, 64);
        chk("to_timeout", timeout, 1); chk("to_winner", winner, 0);
        chk("to_rounds", rounds, 31); chk("to_busy", busy, 0); chk("to_done", done, 1);
        step();
        chk("to_done_low", done, 0); chk("to_timeout_hold", timeout, 1);

        // RESP_LAT=3: moves held 3 cycles, WAIT-cycle manche ignored
        manual = 0; seed = 16'h0001; start3 = 1;
        step(); start3 = 0;
        chk("l3_cfg_ref", ref_reset3, 1);
        step();
        step();
        chk("l3_w1_g1", g1_3, 1); chk("l3_w1_g2", g2_3, 1);
        manche3 = 2'b01;
        step();
        chk("l3_w2_g1", g1_3, 1);
        manche3 = 2'b10;
        step();
        chk("l3_chk_g1", g1_3, 1); chk("l3_chk_g2", g2_3, 1);
        step(); manche3 = 0;
        chk("l3_rounds", rounds3, 1); chk("l3_g1_clear", g1_3, 0);
        step();
        chk("l3_r2_g1", g1_3, 2); chk("l3_r2_g2_rot", g2_3, 2);

        // Reset in WAIT
        reset = 1;
        step(); reset = 0;
        chk("rw_g1", g1_3, 0); chk("rw_g2", g2_3, 0); chk("rw_rounds", rounds3, 0);
        chk("rw_busy", busy3, 0); chk("rw_ref_reset", ref_reset3, 0);
        chk("rw_dut_rounds", rounds, 0); chk("rw_dut_timeout", timeout, 0);
        start3 = 1;
        step(); start3 = 0;
        chk("rw_cfg_ref", ref_reset3, 1); chk("rw_cfg_busy", busy3, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
